// File: rtl/ft601_tx_arbiter.sv
// ft601_tx_arbiter: round-robin grant of two source FIFOs onto one FT601 TX read controller.
// Define FT601_ARB_TIMEOUT_EN to add the XFER watchdog and a sticky error_timeout.
module ft601_tx_arbiter #(
    parameter int unsigned MAX_BURST   = 4096,
    parameter int unsigned PKT_WORDS   = 1024,
    parameter int unsigned GAP_CYC     = 8,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic        ft601_clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] src0_level,
    input  logic [31:0] src1_level,
    input  logic [31:0] src0_rd_data,
    input  logic [31:0] src1_rd_data,
    output logic        src0_rd_en,
    output logic        src1_rd_en,
    output logic        ctrl_rd_start,
    output logic [31:0] ctrl_rd_size,
    output logic [31:0] ctrl_pkt_size,
    input  logic        ctrl_rd_en,
    output logic [31:0] ctrl_rd_data,
    output logic [1:0]  grant,
    output logic        error_timeout
);
    typedef enum logic [1:0] {IDLE, START, XFER, GAP} state_t;
    state_t      r_state, w_state_nxt;
    logic [1:0]  r_grant;
    logic [31:0] r_size, r_cnt, r_gap;
    logic        r_prio1;
    logic        w_req0, w_req1, w_req, w_pick1, w_done, w_gap_end, w_wd_hit;
    logic [31:0] w_level, w_size;

    assign w_req0    = en && (src0_level != 32'd0);
    assign w_req1    = en && (src1_level != 32'd0);
    assign w_req     = w_req0 || w_req1;
    // r_prio1 set means src0 was granted last, so src1 wins a tie
    assign w_pick1   = w_req1 && (!w_req0 || r_prio1);
    assign w_level   = w_pick1 ? src1_level : src0_level;
    assign w_size    = (w_level > MAX_BURST) ? MAX_BURST : w_level;
    assign w_done    = ctrl_rd_en && (r_cnt + 32'd1 == r_size);
    assign w_gap_end = r_gap == GAP_CYC - 1;

`ifdef FT601_ARB_TIMEOUT_EN
    logic [31:0] r_wd;
    logic        r_err;
    assign w_wd_hit = !ctrl_rd_en && (r_wd == TIMEOUT_CYC - 1);
    always_ff @(posedge ft601_clk) begin
        if (reset) begin
            r_wd  <= 32'd0;
            r_err <= 1'b0;
        end else begin
            r_wd <= (r_state == XFER && !ctrl_rd_en) ? r_wd + 32'd1 : 32'd0;
            if (r_state == XFER && w_wd_hit) r_err <= 1'b1;
        end
    end
    assign error_timeout = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = TIMEOUT_CYC != 0;
    assign w_wd_hit         = 1'b0;
    assign error_timeout    = 1'b0;
`endif

    always_ff @(posedge ft601_clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_req ? START : IDLE;
            START:   w_state_nxt = XFER;
            XFER:    w_state_nxt = (w_done || w_wd_hit) ? GAP : XFER;
            GAP:     w_state_nxt = w_gap_end ? IDLE : GAP;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ft601_clk) begin
        if (reset) begin
            r_grant <= 2'b00;
            r_size  <= 32'd0;
            r_cnt   <= 32'd0;
            r_gap   <= 32'd0;
            r_prio1 <= 1'b0;
        end else begin
            r_cnt <= (r_state == XFER) ? r_cnt + {31'd0, ctrl_rd_en} : 32'd0;
            r_gap <= (r_state == GAP) ? r_gap + 32'd1 : 32'd0;
            if (r_state == IDLE && w_req) begin
                r_grant <= w_pick1 ? 2'b10 : 2'b01;
                r_size  <= w_size;
                r_prio1 <= !w_pick1;
            end else if (r_state == GAP && w_gap_end) begin
                r_grant <= 2'b00;
                r_size  <= 32'd0;
            end
        end
    end

    assign grant         = r_grant;
    assign ctrl_rd_size  = r_size;
    assign ctrl_rd_start = r_state == START;
    assign ctrl_pkt_size = PKT_WORDS;
    assign src0_rd_en    = ctrl_rd_en & r_grant[0];
    assign src1_rd_en    = ctrl_rd_en & r_grant[1];
    assign ctrl_rd_data  = r_grant[1] ? src1_rd_data : src0_rd_data;
endmodule

// File: tb/tb_ft601_tx_arbiter.sv
// tb_ft601_tx_arbiter: vector table, directed corner sequences and a randomized run
// against a transfer-level reference model of the arbiter.
module tb_ft601_tx_arbiter;
    localparam int GAP  = 8;
    localparam int MAXB = 4096;
    localparam int TO   = 16;

    logic        ft601_clk = 1'b0;
    logic        reset = 1'b1, en = 1'b0, ctrl_rd_en = 1'b0;
    logic [31:0] src0_level = 0, src1_level = 0, src0_rd_data = 0, src1_rd_data = 0;
    logic        src0_rd_en, src1_rd_en, ctrl_rd_start, error_timeout;
    logic [31:0] ctrl_rd_size, ctrl_pkt_size, ctrl_rd_data;
    logic [1:0]  grant;

    int n_checks = 0;
    int n_err = 0;

    ft601_tx_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .ft601_clk(ft601_clk), .reset(reset), .en(en),
        .src0_level(src0_level), .src1_level(src1_level),
        .src0_rd_data(src0_rd_data), .src1_rd_data(src1_rd_data),
        .src0_rd_en(src0_rd_en), .src1_rd_en(src1_rd_en),
        .ctrl_rd_start(ctrl_rd_start), .ctrl_rd_size(ctrl_rd_size),
        .ctrl_pkt_size(ctrl_pkt_size), .ctrl_rd_en(ctrl_rd_en),
        .ctrl_rd_data(ctrl_rd_data), .grant(grant), .error_timeout(error_timeout)
    );

    always #5 ft601_clk = ~ft601_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ft601_clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; ctrl_rd_en = 1'b0; src0_level = 0; src1_level = 0;
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        en;
        logic [31:0] l0, l1;
        logic [1:0]  g;
        logic [31:0] sz;
    } vec_t;
    vec_t vt[10];

    // transfer-level reference model
    int m_grant, m_size, m_left, m_gap, m_last, m_quiet;
    bit m_start, m_err;

    task automatic model_reset();
        m_grant = 0; m_size = 0; m_left = 0; m_gap = 0; m_last = 1; m_quiet = 0;
        m_start = 0; m_err = 0;
    endtask

    task automatic model_edge();
        bit r0, r1;
        int w;
        logic [31:0] lv;
        if (m_start) begin
            m_start = 0; m_left = m_size; m_quiet = 0;
        end else if (m_left > 0) begin
            if (ctrl_rd_en) begin m_left--; m_quiet = 0; end
            else m_quiet++;
`ifdef FT601_ARB_TIMEOUT_EN
            if (m_left > 0 && m_quiet == TO) begin m_left = 0; m_err = 1; end
`endif
            if (m_left == 0) m_gap = GAP;
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) begin m_grant = 0; m_size = 0; end
        end else begin
            r0 = en && src0_level != 0;
            r1 = en && src1_level != 0;
            if (r0 || r1) begin
                w = (r0 && r1) ? (m_last == 0 ? 1 : 0) : (r1 ? 1 : 0);
                m_last = w;
                m_grant = w ? 2 : 1;
                lv = w ? src1_level : src0_level;
                m_size = (lv > 32'(MAXB)) ? MAXB : int'(lv);
                m_start = 1;
            end
        end
    endtask

    function automatic logic [31:0] rnd_level();
        int r;
        r = $urandom_range(0, 99);
        if (r < 25) return 32'd0;
        if (r < 97) return 32'($urandom_range(1, 12));
        return 32'($urandom);
    endfunction

    initial begin
        #3ms;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int k, bad, starts, stall;
        vt[0] = '{1'b1, 32'd10,    32'd0,          2'b01, 32'd10};
        vt[1] = '{1'b1, 32'd0,     32'd10,         2'b10, 32'd10};
        vt[2] = '{1'b1, 32'd5,     32'd5,          2'b01, 32'd5};
        vt[3] = '{1'b1, 32'd10000, 32'd0,          2'b01, 32'd4096};
        vt[4] = '{1'b1, 32'd4096,  32'd1,          2'b01, 32'd4096};
        vt[5] = '{1'b1, 32'd4097,  32'd0,          2'b01, 32'd4096};
        vt[6] = '{1'b0, 32'd5,     32'd5,          2'b00, 32'd0};
        vt[7] = '{1'b1, 32'd0,     32'd0,          2'b00, 32'd0};
        vt[8] = '{1'b1, 32'd0,     32'hFFFF_FFFF,  2'b10, 32'd4096};
        vt[9] = '{1'b1, 32'd1,     32'd0,          2'b01, 32'd1};

        for (int i = 0; i < 10; i++) begin
            reset = 1'b1; ctrl_rd_en = 1'b1; en = 1'b1; src0_level = 7; src1_level = 7;
            src0_rd_data = 32'hA0A0_0000 + i; src1_rd_data = 32'h5B5B_0000 + i;
            step();
            chk("rst_grant", grant, 0);
            chk("rst_size", ctrl_rd_size, 0);
            chk("rst_start", ctrl_rd_start, 0);
            chk("rst_err", error_timeout, 0);
            chk("rst_rd_en", {src1_rd_en, src0_rd_en}, 0);
            chk("rst_data", ctrl_rd_data, src0_rd_data);
            chk("pkt_size", ctrl_pkt_size, 1024);
            reset = 1'b0; ctrl_rd_en = 1'b0;
            en = vt[i].en; src0_level = vt[i].l0; src1_level = vt[i].l1;
            step();
            chk("vec_start", ctrl_rd_start, vt[i].g != 0);
            chk("vec_grant", grant, vt[i].g);
            chk("vec_size", ctrl_rd_size, vt[i].sz);
        end

        // single src0 burst of 10 with exact gap length
        do_reset();
        en = 1; src0_level = 10;
        step();
        chk("a_start", ctrl_rd_start, 1);
        chk("a_grant", grant, 2'b01);
        chk("a_size", ctrl_rd_size, 10);
        step();
        chk("a_start_once", ctrl_rd_start, 0);
        ctrl_rd_en = 1; k = 0; bad = 0;
        repeat (10) begin
            #1; k += src0_rd_en; bad += src1_rd_en;
            step();
        end
        ctrl_rd_en = 0; src0_level = 0;
        chk("a_reads0", k, 10);
        chk("a_reads1", bad, 0);
        chk("a_gap_grant", grant, 2'b01);
        repeat (GAP - 1) step();
        chk("a_gap_end_grant", grant, 2'b01);
        chk("a_gap_end_size", ctrl_rd_size, 10);
        step();
        chk("a_idle_grant", grant, 0);
        chk("a_idle_size", ctrl_rd_size, 0);

        // both requesting continuously: strict alternation, no cross reads
        do_reset();
        en = 1; src0_level = 5; src1_level = 5; ctrl_rd_en = 1;
        k = 0; bad = 0;
        for (int c = 0; c < 400 && k < 4; c++) begin
            step();
            if (grant == 2'b01 && src1_rd_en) bad++;
            if (grant == 2'b10 && src0_rd_en) bad++;
            if (ctrl_rd_start) begin
                chk("rr_grant", grant, (k % 2) ? 2'b10 : 2'b01);
                k++;
            end
        end
        chk("rr_starts", k, 4);
        chk("rr_cross_rd", bad, 0);

        // capped burst, level changes ignored mid-transfer, next size fresh
        do_reset();
        en = 1; src1_level = 10000;
        step();
        chk("c_size", ctrl_rd_size, 4096);
        chk("c_grant", grant, 2'b10);
        src1_level = 7; ctrl_rd_en = 1;
        repeat (50) step();
        chk("c_size_held", ctrl_rd_size, 4096);
        k = 0;
        for (int c = 0; c < 5000 && k == 0; c++) begin
            step();
            if (ctrl_rd_start) k = 1;
        end
        chk("c_restart", k, 1);
        chk("c_size2", ctrl_rd_size, 7);
        chk("c_grant2", grant, 2'b10);

        // en dropped after 3 of 10 reads
        do_reset();
        en = 1; src0_level = 10;
        step(); step();
        ctrl_rd_en = 1;
        repeat (3) step();
        en = 0;
        repeat (7) step();
        ctrl_rd_en = 0;
        chk("d_gap_grant", grant, 2'b01);
        repeat (GAP - 1) step();
        chk("d_gap_end_grant", grant, 2'b01);
        step();
        chk("d_idle_grant", grant, 0);
        starts = 0;
        repeat (30) begin step(); starts += ctrl_rd_start; end
        chk("d_no_start_en0", starts, 0);
        en = 1;
        step();
        chk("d_regrant", {ctrl_rd_start, grant}, 3'b101);

        // reads stall after 2 of 10
        do_reset();
        en = 1; src0_level = 10;
        step(); step();
        ctrl_rd_en = 1;
        repeat (2) step();
        ctrl_rd_en = 0; src0_level = 0;
        repeat (TO - 1) step();
        chk("e_err_early", error_timeout, 0);
        chk("e_grant_early", grant, 2'b01);
        step();
`ifdef FT601_ARB_TIMEOUT_EN
        chk("e_err_set", error_timeout, 1);
        repeat (GAP) step();
        chk("e_idle_grant", grant, 0);
        chk("e_err_sticky", error_timeout, 1);
        do_reset();
        chk("e_err_cleared", error_timeout, 0);
`else
        chk("e_err_tied", error_timeout, 0);
        chk("e_still_xfer", grant, 2'b01);
        ctrl_rd_en = 1;
        repeat (8) step();
        ctrl_rd_en = 0;
        repeat (GAP) step();
        chk("e_idle_grant", grant, 0);
`endif

        // reset mid-transfer abandons it and restores src0 priority
        do_reset();
        en = 1; src0_level = 10; src1_level = 10;
        src0_rd_data = 32'h1111_0000; src1_rd_data = 32'h2222_0000;
        step(); step();
        ctrl_rd_en = 1;
        repeat (3) step();
        reset = 1;
        step();
        chk("r_grant", grant, 0);
        chk("r_size", ctrl_rd_size, 0);
        chk("r_start", ctrl_rd_start, 0);
        chk("r_rd_en", {src1_rd_en, src0_rd_en}, 0);
        chk("r_data", ctrl_rd_data, 32'h1111_0000);
        reset = 0;
        step();
        chk("r_regrant", {ctrl_rd_start, grant}, 3'b101);

        // randomized run against the reference model
        do_reset();
        model_reset();
        stall = 0;
        for (int c = 0; c < 15000; c++) begin
            chk("rnd_grant", grant, m_grant);
            chk("rnd_size", ctrl_rd_size, m_size);
            chk("rnd_start", ctrl_rd_start, m_start);
            chk("rnd_err", error_timeout, m_err);
            en = $urandom_range(0, 99) < 85;
            src0_level = rnd_level();
            src1_level = rnd_level();
            src0_rd_data = $urandom;
            src1_rd_data = $urandom;
            if (stall > 0) begin
                ctrl_rd_en = 0; stall--;
            end else begin
                if ($urandom_range(0, 299) == 0) stall = 20;
                ctrl_rd_en = $urandom_range(0, 9) < 7;
            end
            #1;
            chk("rnd_rd_en0", src0_rd_en, ctrl_rd_en && m_grant == 1);
            chk("rnd_rd_en1", src1_rd_en, ctrl_rd_en && m_grant == 2);
            chk("rnd_data", ctrl_rd_data, (m_grant == 2) ? src1_rd_data : src0_rd_data);
            model_edge();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
